// File: rtl/mul_fu_arbiter.sv
// Round-robin front end that shares one signed multiplier among several
// reservation stations and returns the chosen 32-bit half of each product,
// tagged, to the CDB. A flush squashes the in-flight operation while still
// draining the multiplier so its handshake stays consistent.
module mul_fu_arbiter #(
    parameter int data_width_p = 32,
    parameter int NUM_REQ_P    = 4,
    parameter int tag_width_p  = 5
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ_P-1:0]               req_v_i,
    input  logic [NUM_REQ_P*data_width_p-1:0]  req_a_i,
    input  logic [NUM_REQ_P*data_width_p-1:0]  req_b_i,
    input  logic [NUM_REQ_P*tag_width_p-1:0]   req_tag_i,
    input  logic [NUM_REQ_P-1:0]               req_hi_i,
    output logic [NUM_REQ_P-1:0]               req_yumi_o,
    output logic                               mult_v_o,
    input  logic                               mult_ready_i,
    output logic [data_width_p-1:0]            mult_a_o,
    output logic [data_width_p-1:0]            mult_b_o,
    input  logic                               mult_v_i,
    input  logic [2*data_width_p-1:0]          mult_data_i,
    output logic                               mult_yumi_o,
    output logic                               cdb_v_o,
    output logic [tag_width_p-1:0]             cdb_tag_o,
    output logic [data_width_p-1:0]            cdb_data_o,
    input  logic                               cdb_yumi_i,
    output logic                               busy_o
);

    localparam int RR_W = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_BUSY   = 2'd2,
        S_RESULT = 2'd3
    } state_e;

    state_e                   r_state;
    logic [RR_W-1:0]          r_rr;
    logic                     r_kill;
    logic [data_width_p-1:0]  r_a;
    logic [data_width_p-1:0]  r_b;
    logic [tag_width_p-1:0]   r_tag;
    logic                     r_hi;
    logic [data_width_p-1:0]  r_cdb_data;

    logic [NUM_REQ_P-1:0]     w_grant;
    logic [RR_W-1:0]          w_gidx;
    logic                     w_found;
    logic                     w_can_grant;

    assign w_can_grant = (r_state == S_IDLE) && !flush_i && !reset_i;

    // Round-robin scan starting one past the last winner; first valid wins.
    always_comb begin : grant_scan
        int v_idx;
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        v_idx   = 0;
        for (int i = 0; i < NUM_REQ_P; i++) begin
            v_idx = int'(r_rr) + 1 + i;
            if (v_idx >= NUM_REQ_P) begin
                v_idx = v_idx - NUM_REQ_P;
            end else begin
                v_idx = v_idx;
            end
            if (w_can_grant && !w_found && req_v_i[v_idx]) begin
                w_grant[v_idx] = 1'b1;
                w_gidx         = RR_W'(v_idx);
                w_found        = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Control FSM: grant, issue to the multiplier, drain its result, broadcast.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_rr    <= RR_W'(NUM_REQ_P - 1);
            r_kill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_found) begin
                        r_rr    <= w_gidx;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (mult_ready_i) begin
                        // Multiplier took the operands; a concurrent flush must
                        // still drain it, so remember to discard the result.
                        r_kill  <= flush_i;
                        r_state <= S_BUSY;
                    end else if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_BUSY: begin
                    if (mult_v_i) begin
                        r_state <= (r_kill || flush_i) ? S_IDLE : S_RESULT;
                    end else if (flush_i) begin
                        r_kill <= 1'b1;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_RESULT: begin
                    if (cdb_yumi_i || flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RESULT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand/tag capture at grant and product-half capture at drain.
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_found) begin
            r_a   <= req_a_i[int'(w_gidx)*data_width_p +: data_width_p];
            r_b   <= req_b_i[int'(w_gidx)*data_width_p +: data_width_p];
            r_tag <= req_tag_i[int'(w_gidx)*tag_width_p +: tag_width_p];
            r_hi  <= req_hi_i[w_gidx];
        end else begin
            r_hi  <= r_hi;
        end
        if (!reset_i && (r_state == S_BUSY) && mult_v_i) begin
            r_cdb_data <= r_hi ? mult_data_i[2*data_width_p-1:data_width_p]
                               : mult_data_i[data_width_p-1:0];
        end else begin
            r_cdb_data <= r_cdb_data;
        end
    end

    assign req_yumi_o  = w_grant;
    assign mult_v_o    = !reset_i && (r_state == S_ISSUE);
    assign mult_a_o    = r_a;
    assign mult_b_o    = r_b;
    assign mult_yumi_o = !reset_i && (r_state == S_BUSY) && mult_v_i;
    assign cdb_v_o     = !reset_i && (r_state == S_RESULT);
    assign cdb_tag_o   = r_tag;
    assign cdb_data_o  = r_cdb_data;
    assign busy_o      = !reset_i && (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_fu_arbiter.sv
// Directed bench for mul_fu_arbiter with a small latency multiplier model.
module tb_mul_fu_arbiter;

    logic         clk = 1'b0;
    logic         reset_i, flush_i;
    logic [3:0]   req_v_i, req_hi_i, req_yumi_o;
    logic [127:0] req_a_i, req_b_i;
    logic [19:0]  req_tag_i;
    logic         mult_v_o, mult_ready_i, mult_v_i, mult_yumi_o;
    logic [31:0]  mult_a_o, mult_b_o, cdb_data_o;
    logic [63:0]  mult_data_i;
    logic         cdb_v_o, cdb_yumi_i, busy_o;
    logic [4:0]   cdb_tag_o;

    int n_cmp = 0;
    int n_fail = 0;

    mul_fu_arbiter #(.data_width_p(32), .NUM_REQ_P(4), .tag_width_p(5)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .req_v_i(req_v_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_tag_i(req_tag_i), .req_hi_i(req_hi_i), .req_yumi_o(req_yumi_o),
        .mult_v_o(mult_v_o), .mult_ready_i(mult_ready_i),
        .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
        .mult_v_i(mult_v_i), .mult_data_i(mult_data_i), .mult_yumi_o(mult_yumi_o),
        .cdb_v_o(cdb_v_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
        .cdb_yumi_i(cdb_yumi_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Multiplier model: accepts when idle, result valid 5 edges later, held until yumi.
    logic        m_busy, m_valid;
    logic [2:0]  m_cnt;
    logic [63:0] m_prod;
    assign mult_ready_i = !m_busy;
    assign mult_v_i     = m_valid;
    assign mult_data_i  = m_prod;
    always @(posedge clk) begin
        if (reset_i) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 3'd0; m_prod <= 64'd0;
        end else if (!m_busy && mult_v_o) begin
            m_busy <= 1'b1; m_cnt <= 3'd4;
            m_prod <= $signed(mult_a_o) * $signed(mult_b_o);
        end else if (m_busy && !m_valid) begin
            if (m_cnt == 3'd0) m_valid <= 1'b1;
            else m_cnt <= m_cnt - 3'd1;
        end else if (m_valid && mult_yumi_o) begin
            m_valid <= 1'b0; m_busy <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic hi);
        req_a_i[k*32 +: 32] = a;
        req_b_i[k*32 +: 32] = b;
        req_tag_i[k*5 +: 5] = tag;
        req_hi_i[k]         = hi;
    endtask

    // Wait (bounded) for cdb_v_o, then check data and tag.
    task automatic wait_cdb(input logic [31:0] exp_data, input logic [4:0] exp_tag);
        int n = 0;
        while (!cdb_v_o && n < 40) begin
            tick;
            n++;
        end
        check("cdb_v", {63'd0, cdb_v_o}, 64'd1);
        check("cdb_data", {32'd0, cdb_data_o}, {32'd0, exp_data});
        check("cdb_tag", {59'd0, cdb_tag_o}, {59'd0, exp_tag});
    endtask

    // One complete operation on requester k with bp cycles of CDB backpressure.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic hi,
                         input logic [31:0] exp_data, input int bp);
        set_req(k, a, b, tag, hi);
        req_v_i = 4'd0;
        req_v_i[k] = 1'b1;
        #1;
        check("grant", {60'd0, req_yumi_o}, 64'd1 << k);
        tick;
        req_v_i = 4'd0;
        #1;
        check("mult_v", {63'd0, mult_v_o}, 64'd1);
        check("mult_a", {32'd0, mult_a_o}, {32'd0, a});
        wait_cdb(exp_data, tag);
        for (int i = 0; i < bp; i++) begin
            req_v_i = 4'd0;
            req_v_i[(k + 1) % 4] = 1'b1;
            tick;
            check("bp_cdb_v", {63'd0, cdb_v_o}, 64'd1);
            check("bp_data", {32'd0, cdb_data_o}, {32'd0, exp_data});
            check("bp_tag", {59'd0, cdb_tag_o}, {59'd0, tag});
            check("bp_no_grant", {60'd0, req_yumi_o}, 64'd0);
        end
        req_v_i = 4'd0;
        cdb_yumi_i = 1'b1;
        tick;
        cdb_yumi_i = 1'b0;
        #1;
        check("cdb_v_drop", {63'd0, cdb_v_o}, 64'd0);
        check("busy_drop", {63'd0, busy_o}, 64'd0);
    endtask

    // Hold a request pattern and check grant order; requester k returns 10*(k+1).
    task automatic rr_seq(input logic [3:0] pat, input logic [4:0][1:0] order, input int cnt);
        req_v_i = pat;
        for (int j = 0; j < cnt; j++) begin
            int n = 0;
            int k;
            k = int'(order[j]);
            #1;
            while (req_yumi_o == 4'd0 && n < 20) begin
                @(posedge clk);
                #2;
                n++;
            end
            check("rr_grant", {60'd0, req_yumi_o}, 64'd1 << k);
            tick;
            wait_cdb(32'(10 * (k + 1)), 5'(k));
            cdb_yumi_i = 1'b1;
            tick;
            cdb_yumi_i = 1'b0;
        end
        req_v_i = 4'd0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {59'd0, req_yumi_o, mult_v_o, mult_yumi_o, cdb_v_o, busy_o}, 64'd0);
    endtask

    initial begin
        bit saw_yumi, saw_cdb;
        reset_i = 1'b1; flush_i = 1'b0; cdb_yumi_i = 1'b0;
        req_v_i = 4'd0; req_hi_i = 4'd0;
        req_a_i = '0; req_b_i = '0; req_tag_i = '0;

        // Reset state
        tick; tick;
        req_v_i = 4'b1111;
        #1;
        check_all_zero("reset_outs");
        req_v_i = 4'd0;
        reset_i = 1'b0;
        tick;

        // Single op 7 * -3 with 10 cycles of CDB backpressure
        do_op(0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, 32'hFFFF_FFEB, 10);
        // MULH / MUL of 0x80000000 squared
        do_op(1, 32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1, 32'h4000_0000, 0);
        do_op(2, 32'h8000_0000, 32'h8000_0000, 5'd10, 1'b0, 32'h0000_0000, 0);

        // Round robin from a fresh reset
        reset_i = 1'b1; tick; reset_i = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 32'(k + 1), 32'd10, 5'(k), 1'b0);
        rr_seq(4'b1111, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 5);
        rr_seq(4'b1010, {2'd0, 2'd0, 2'd1, 2'd3, 2'd1}, 3);
        tick;

        // Flush while the multiplier is busy
        set_req(0, 32'd6, 32'd7, 5'd3, 1'b0);
        req_v_i = 4'b0001;
        #1;
        check("flush_grant", {60'd0, req_yumi_o}, 64'd1);
        tick;
        req_v_i = 4'd0;
        tick;           // operands accepted by the multiplier here
        tick; tick; tick;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        saw_yumi = 1'b0; saw_cdb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            saw_yumi |= mult_yumi_o;
            saw_cdb  |= cdb_v_o;
            tick;
        end
        check("flush_yumi_seen", {63'd0, saw_yumi}, 64'd1);
        check("flush_no_cdb", {63'd0, saw_cdb}, 64'd0);
        check("flush_busy", {63'd0, busy_o}, 64'd0);
        do_op(3, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 5'd17, 1'b0, 32'd25, 0);

        // Reset in the middle of a busy operation
        set_req(2, 32'd3, 32'd4, 5'd1, 1'b0);
        req_v_i = 4'b0100;
        tick;
        req_v_i = 4'd0;
        tick; tick;
        check("pre_reset_busy", {63'd0, busy_o}, 64'd1);
        reset_i = 1'b1;
        req_v_i = 4'b0100;
        tick;
        check_all_zero("mid_reset_outs");
        reset_i = 1'b0;
        req_v_i = 4'd0;
        #1;
        check_all_zero("post_reset_outs");
        tick;
        do_op(2, 32'h1234_5678, 32'h0000_0100, 5'd21, 1'b1, 32'h0000_0012, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
